// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared byte width and FSM state types for the CPU I/O port agent
package io_port_pkg;

  localparam int BYTE_W = 8;

  // Capture side: take a byte from OUTR, pulse the ack, wait for the CPU to see it
  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ACK  = 2'd1,
    CAP_WAIT = 2'd2
  } cap_state_t;

  // Delivery side: load INPR, strobe, then follow the CPU flag through set and clear
  typedef enum logic [1:0] {
    DLV_IDLE     = 2'd0,
    DLV_STROBE   = 2'd1,
    DLV_WAIT_SET = 2'd2,
    DLV_WAIT_CLR = 2'd3
  } dlv_state_t;

endpackage

// File: rtl/io_port_agent_if.sv
// rtl/io_port_agent_if.sv - CPU flag handshake and host valid/ready signals of the I/O port agent
interface io_port_agent_if;
  import io_port_pkg::*;

  // CPU side
  logic [BYTE_W-1:0] cpu_outr;
  logic              cpu_out_flag;
  logic              cpu_out_flag_set;
  logic [BYTE_W-1:0] cpu_inp;
  logic              cpu_inp_flag;
  logic              cpu_inp_strobe;

  // Host side
  logic [BYTE_W-1:0] host_rx_data;
  logic              host_rx_valid;
  logic              host_rx_ready;
  logic [BYTE_W-1:0] host_tx_data;
  logic              host_tx_valid;
  logic              host_tx_ready;

  // The agent (device end of the handshake)
  modport master (
    input  cpu_outr,
    input  cpu_out_flag,
    output cpu_out_flag_set,
    output cpu_inp,
    input  cpu_inp_flag,
    output cpu_inp_strobe,
    output host_rx_data,
    output host_rx_valid,
    input  host_rx_ready,
    input  host_tx_data,
    input  host_tx_valid,
    output host_tx_ready
  );

  // The CPU and host environment around the agent
  modport slave (
    output cpu_outr,
    output cpu_out_flag,
    input  cpu_out_flag_set,
    input  cpu_inp,
    output cpu_inp_flag,
    input  cpu_inp_strobe,
    input  host_rx_data,
    input  host_rx_valid,
    output host_rx_ready,
    output host_tx_data,
    output host_tx_valid,
    input  host_tx_ready
  );

endinterface

// File: rtl/io_port_fifo.sv
// rtl/io_port_fifo.sv - byte FIFO with wrap-bit pointers, simultaneous push/pop, combinational head
module io_port_fifo
  import io_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [BYTE_W-1:0] o_head
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_push_ok;
  logic              w_pop_ok;

  // A full FIFO refuses a push even when a pop happens in the same cycle
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Extra pointer bit distinguishes full from empty when the low bits match
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO without touching storage
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents past the read pointer are never observed
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/io_port_agent.sv
// rtl/io_port_agent.sv - CPU OUTR/INPR flag-handshake agent with host FIFOs; optional IO_PORT_LOOPBACK_EN
module io_port_agent
  import io_port_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic clock,
  input  logic reset,
`ifdef IO_PORT_LOOPBACK_EN
  input  logic loopback,
`endif
  io_port_agent_if.master bus
);

  logic              w_out_push;
  logic              w_out_pop;
  logic              w_out_full;
  logic              w_out_empty;
  logic [BYTE_W-1:0] w_out_head;

  logic              w_in_push;
  logic              w_in_pop;
  logic              w_in_full;
  logic              w_in_empty;
  logic [BYTE_W-1:0] w_in_head;
  logic [BYTE_W-1:0] w_in_push_data;

  logic              w_cap_full;
  logic              w_cap_fire;
  logic              w_dlv_fire;
  logic              w_rx_valid;
  logic              w_tx_ready;

  cap_state_t        r_cap_state;
  dlv_state_t        r_dlv_state;
  logic              r_flag_set;
  logic              r_inp_strobe;
  logic [BYTE_W-1:0] r_cpu_inp;

`ifdef IO_PORT_LOOPBACK_EN
  // Loopback steers captured bytes into the in-FIFO and closes both host ports
  assign w_cap_full     = loopback ? w_in_full : w_out_full;
  assign w_out_push     = w_cap_fire && !loopback;
  assign w_in_push      = loopback ? w_cap_fire : (bus.host_tx_valid && !w_in_full);
  assign w_in_push_data = loopback ? bus.cpu_outr : bus.host_tx_data;
  assign w_rx_valid     = !w_out_empty && !loopback;
  assign w_tx_ready     = !w_in_full && !loopback;
`else
  assign w_cap_full     = w_out_full;
  assign w_out_push     = w_cap_fire;
  assign w_in_push      = bus.host_tx_valid && !w_in_full;
  assign w_in_push_data = bus.host_tx_data;
  assign w_rx_valid     = !w_out_empty;
  assign w_tx_ready     = !w_in_full;
`endif

  // A byte waiting in OUTR is taken only when there is room, so it is never lost
  assign w_cap_fire = (r_cap_state == CAP_IDLE) && !bus.cpu_out_flag && !w_cap_full;
  assign w_out_pop  = w_rx_valid && bus.host_rx_ready;

  // Next byte goes to the CPU only once INPR has been read
  assign w_dlv_fire = (r_dlv_state == DLV_IDLE) && !w_in_empty && !bus.cpu_inp_flag;
  assign w_in_pop   = w_dlv_fire;

  assign bus.host_rx_data     = w_out_head;
  assign bus.host_rx_valid    = w_rx_valid;
  assign bus.host_tx_ready    = w_tx_ready;
  assign bus.cpu_out_flag_set = r_flag_set;
  assign bus.cpu_inp_strobe   = r_inp_strobe;
  assign bus.cpu_inp          = r_cpu_inp;

  io_port_fifo #(.DEPTH(DEPTH), .AW(AW)) u_out_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_out_push),
    .i_push_data (bus.cpu_outr),
    .i_pop       (w_out_pop),
    .o_full      (w_out_full),
    .o_empty     (w_out_empty),
    .o_head      (w_out_head)
  );

  io_port_fifo #(.DEPTH(DEPTH), .AW(AW)) u_in_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_in_push),
    .i_push_data (w_in_push_data),
    .i_pop       (w_in_pop),
    .o_full      (w_in_full),
    .o_empty     (w_in_empty),
    .o_head      (w_in_head)
  );

  // Capture FSM: push OUTR, ack for one cycle, then wait for the CPU flag to return high
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cap_state <= CAP_IDLE;
      r_flag_set  <= 1'b0;
    end else begin
      case (r_cap_state)
        CAP_IDLE: begin
          if (w_cap_fire) begin
            r_cap_state <= CAP_ACK;
            r_flag_set  <= 1'b1;
          end
        end
        CAP_ACK: begin
          r_cap_state <= CAP_WAIT;
          r_flag_set  <= 1'b0;
        end
        CAP_WAIT: begin
          // Stale low flag from the previous byte must not trigger a second capture
          if (bus.cpu_out_flag) r_cap_state <= CAP_IDLE;
        end
        default: begin
          r_cap_state <= CAP_IDLE;
          r_flag_set  <= 1'b0;
        end
      endcase
    end
  end

  // Delivery FSM: load INPR and strobe, then track the CPU flag through set and clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dlv_state  <= DLV_IDLE;
      r_inp_strobe <= 1'b0;
      r_cpu_inp    <= '0;
    end else begin
      case (r_dlv_state)
        DLV_IDLE: begin
          if (w_dlv_fire) begin
            r_cpu_inp    <= w_in_head;
            r_inp_strobe <= 1'b1;
            r_dlv_state  <= DLV_STROBE;
          end
        end
        DLV_STROBE: begin
          r_inp_strobe <= 1'b0;
          r_dlv_state  <= DLV_WAIT_SET;
        end
        DLV_WAIT_SET: begin
          if (bus.cpu_inp_flag) r_dlv_state <= DLV_WAIT_CLR;
        end
        DLV_WAIT_CLR: begin
          if (!bus.cpu_inp_flag) r_dlv_state <= DLV_IDLE;
        end
        default: begin
          r_dlv_state  <= DLV_IDLE;
          r_inp_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_agent.sv
// tb/tb_io_port_agent.sv - self-checking bench for io_port_agent with queue-level reference model
`timescale 1ns/1ps
module tb_io_port_agent;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef IO_PORT_LOOPBACK_EN
  logic lb_in = 1'b0;
  wire  lb_eff = lb_in;
`else
  wire  lb_eff = 1'b0;
`endif

  always #5 clock = ~clock;

  io_port_agent_if bus ();

  io_port_agent #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
`ifdef IO_PORT_LOOPBACK_EN
    .loopback (lb_in),
`endif
    .bus      (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queues plus busy markers for each handshake
  logic [7:0] m_out_q[$];
  logic [7:0] m_in_q[$];
  bit         m_flag_set   = 1'b0;
  bit         m_strobe     = 1'b0;
  logic [7:0] m_inp        = 8'h00;
  bit         m_cap_busy   = 1'b0;
  bit         m_dlv_busy   = 1'b0;
  bit         m_dlv_seen   = 1'b0;

  always @(posedge clock) begin : model
    bit rx_go, tx_go, cap_go, dlv_go;
    if (reset) begin
      m_out_q.delete();
      m_in_q.delete();
      m_flag_set = 1'b0;
      m_strobe   = 1'b0;
      m_inp      = 8'h00;
      m_cap_busy = 1'b0;
      m_dlv_busy = 1'b0;
      m_dlv_seen = 1'b0;
    end else begin
      rx_go  = (m_out_q.size() != 0) && !lb_eff && bus.host_rx_ready;
      tx_go  = !lb_eff && bus.host_tx_valid && (m_in_q.size() < DEPTH);
      cap_go = !m_cap_busy && !bus.cpu_out_flag &&
               ((lb_eff ? m_in_q.size() : m_out_q.size()) < DEPTH);
      dlv_go = !m_dlv_busy && (m_in_q.size() != 0) && !bus.cpu_inp_flag;
      // capture is released once the flag is back high after the ack cycle
      if (m_cap_busy && !m_flag_set && bus.cpu_out_flag) m_cap_busy = 1'b0;
      // delivery is released after the CPU flag has gone high and then low again
      if (m_dlv_busy && !m_strobe) begin
        if (!m_dlv_seen) begin
          if (bus.cpu_inp_flag) m_dlv_seen = 1'b1;
        end else if (!bus.cpu_inp_flag) begin
          m_dlv_busy = 1'b0;
          m_dlv_seen = 1'b0;
        end
      end
      if (rx_go) void'(m_out_q.pop_front());
      if (dlv_go) m_inp = m_in_q.pop_front();
      if (tx_go) m_in_q.push_back(bus.host_tx_data);
      if (cap_go) begin
        if (lb_eff) m_in_q.push_back(bus.cpu_outr);
        else        m_out_q.push_back(bus.cpu_outr);
      end
      m_flag_set = cap_go;
      m_strobe   = dlv_go;
      if (cap_go) m_cap_busy = 1'b1;
      if (dlv_go) m_dlv_busy = 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model, 1 ns after the edge
  always @(posedge clock) begin
    #1;
    chk("cyc_flag_set", bus.cpu_out_flag_set, m_flag_set);
    chk("cyc_inp_strobe", bus.cpu_inp_strobe, m_strobe);
    chk("cyc_cpu_inp", bus.cpu_inp, m_inp);
    chk("cyc_rx_valid", bus.host_rx_valid, (m_out_q.size() != 0) && !lb_eff);
    chk("cyc_tx_ready", bus.host_tx_ready, (m_in_q.size() < DEPTH) && !lb_eff);
    if (m_out_q.size() != 0) chk("cyc_rx_data", bus.host_rx_data, m_out_q[0]);
  end

  // CPU model and monitors, acting on the falling edge
  logic [7:0] cpu_tx_q[$];
  logic [7:0] got_inp[$];
  logic [7:0] got_rx[$];
  int         strb_cyc[$];
  int         ack_cnt  = 0;
  int         strb_cnt = 0;
  int         ncyc     = 0;
  int         clr_cyc  = 0;
  bit         cpu_inp_auto = 1'b1;

  initial begin : cpu_model
    int out_cnt;
    int inp_timer;
    out_cnt   = 0;
    inp_timer = 0;
    bus.cpu_outr     = 8'h00;
    bus.cpu_out_flag = 1'b1;
    bus.cpu_inp_flag = 1'b0;
    forever begin
      @(negedge clock);
      ncyc++;
      if (reset) begin
        bus.cpu_out_flag = 1'b1;
        bus.cpu_inp_flag = 1'b0;
        out_cnt   = 0;
        inp_timer = 0;
      end else begin
        if (bus.cpu_out_flag_set) begin
          ack_cnt++;
          out_cnt = 2;
        end else if (out_cnt > 0) begin
          out_cnt--;
          if (out_cnt == 0) bus.cpu_out_flag = 1'b1;
        end else if (bus.cpu_out_flag && cpu_tx_q.size() != 0) begin
          bus.cpu_outr     = cpu_tx_q.pop_front();
          bus.cpu_out_flag = 1'b0;
        end
        if (bus.cpu_inp_strobe) begin
          strb_cnt++;
          got_inp.push_back(bus.cpu_inp);
          strb_cyc.push_back(ncyc);
          if (cpu_inp_auto) inp_timer = 1;
        end else if (inp_timer > 0) begin
          inp_timer++;
          if (inp_timer == 2) bus.cpu_inp_flag = 1'b1;
          if (inp_timer == 7) begin
            bus.cpu_inp_flag = 1'b0;
            inp_timer = 0;
            clr_cyc   = ncyc;
          end
        end
        if (bus.host_rx_valid && bus.host_rx_ready) got_rx.push_back(bus.host_rx_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic host_send(input logic [7:0] b);
    int n;
    bus.host_tx_data  = b;
    bus.host_tx_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.host_tx_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("tx_accept_in_time", (n < 200), 1);
    @(posedge clock);
    #2;
  endtask

  initial begin : main
    int base_ack;
    int base_strb;
    int n;
    bus.host_tx_data  = 8'h00;
    bus.host_tx_valid = 1'b0;
    bus.host_rx_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;

    // idle after reset
    tick(20);
    chk("idle_acks", ack_cnt, 0);
    chk("idle_strobes", strb_cnt, 0);
    chk("idle_tx_ready", bus.host_tx_ready, 1);
    chk("idle_rx_valid", bus.host_rx_valid, 0);
    chk("idle_cpu_inp", bus.cpu_inp, 8'h00);

    // single CPU write
    base_ack = ack_cnt;
    got_rx.delete();
    cpu_tx_q.push_back(8'hA5);
    n = 0;
    while (ack_cnt < base_ack + 1 && n < 50) begin tick(1); n++; end
    chk("a5_ack", ack_cnt - base_ack, 1);
    tick(4);
    chk("a5_rx_data", bus.host_rx_data, 8'hA5);
    chk("a5_rx_valid", bus.host_rx_valid, 1);
    chk("a5_single_ack", ack_cnt - base_ack, 1);
    bus.host_rx_ready = 1'b1;
    tick(1);
    bus.host_rx_ready = 1'b0;
    tick(1);
    chk("a5_popped_count", got_rx.size(), 1);
    chk("a5_popped_byte", got_rx[0], 8'hA5);
    chk("a5_rx_empty", bus.host_rx_valid, 0);

    // two host bytes delivered one at a time
    got_inp.delete();
    strb_cyc.delete();
    base_strb = strb_cnt;
    host_send(8'h3C);
    host_send(8'h7E);
    bus.host_tx_valid = 1'b0;
    n = 0;
    while (strb_cnt < base_strb + 2 && n < 100) begin tick(1); n++; end
    chk("dlv_two_strobes", strb_cnt - base_strb, 2);
    chk("dlv_byte0", got_inp[0], 8'h3C);
    chk("dlv_byte1", got_inp[1], 8'h7E);
    chk("dlv_after_clear", strb_cyc[1] - clr_cyc, 2);
    tick(12);

    // out-FIFO full: fifth byte held in OUTR until space frees
    got_rx.delete();
    base_ack = ack_cnt;
    for (int i = 1; i <= 5; i++) cpu_tx_q.push_back(8'(i));
    tick(40);
    chk("full_acks", ack_cnt - base_ack, 4);
    chk("full_model_depth", m_out_q.size(), 4);
    chk("full_rx_valid", bus.host_rx_valid, 1);
    chk("full_head", bus.host_rx_data, 8'h01);
    chk("full_tx_ready", bus.host_tx_ready, 1);
    bus.host_rx_ready = 1'b1;
    n = 0;
    while ((ack_cnt < base_ack + 5 || got_rx.size() < 5) && n < 100) begin tick(1); n++; end
    bus.host_rx_ready = 1'b0;
    chk("drain_acks", ack_cnt - base_ack, 5);
    chk("drain_count", got_rx.size(), 5);
    for (int i = 0; i < 5; i++) chk("drain_byte", got_rx[i], i + 1);
    tick(5);

    // reset while waiting for the CPU flag, with bytes still queued
    cpu_inp_auto = 1'b0;
    base_strb = strb_cnt;
    host_send(8'h11);
    host_send(8'h22);
    host_send(8'h33);
    bus.host_tx_valid = 1'b0;
    n = 0;
    while (strb_cnt < base_strb + 1 && n < 50) begin tick(1); n++; end
    tick(3);
    chk("pre_rst_strobes", strb_cnt - base_strb, 1);
    chk("pre_rst_cpu_inp", bus.cpu_inp, 8'h11);
    chk("pre_rst_model_queued", m_in_q.size(), 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    base_strb = strb_cnt;
    tick(20);
    chk("rst_no_strobe", strb_cnt - base_strb, 0);
    chk("rst_tx_ready", bus.host_tx_ready, 1);
    chk("rst_cpu_inp", bus.cpu_inp, 8'h00);
    chk("rst_rx_valid", bus.host_rx_valid, 0);
    cpu_inp_auto = 1'b1;

`ifdef IO_PORT_LOOPBACK_EN
    // loopback: captured byte returns to the CPU, host ports closed
    lb_in = 1'b1;
    base_ack  = ack_cnt;
    base_strb = strb_cnt;
    got_inp.delete();
    cpu_tx_q.push_back(8'h5A);
    n = 0;
    while (strb_cnt < base_strb + 1 && n < 50) begin tick(1); n++; end
    chk("lb_ack", ack_cnt - base_ack, 1);
    chk("lb_strobe", strb_cnt - base_strb, 1);
    chk("lb_byte", got_inp[0], 8'h5A);
    chk("lb_rx_valid", bus.host_rx_valid, 0);
    chk("lb_tx_ready", bus.host_tx_ready, 0);
    tick(10);
    lb_in = 1'b0;
    tick(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
